// File: rtl/gate_stim_checker_if.sv
// Bundles the stimulus/response signals between the checker and the bench
// that hosts the gate under test.
interface gate_stim_checker_if;
  logic       start;
  logic [1:0] op;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic       pass;
  logic       mismatch;
  logic [2:0] err_count;
  logic [1:0] first_fail;

  modport master (
    output start, op, c,
    input  a, b, busy, done, pass, mismatch, err_count, first_fail
  );

  modport slave (
    input  start, op, c,
    output a, b, busy, done, pass, mismatch, err_count, first_fail
  );
endinterface

// File: rtl/gate_stim_checker.sv
// Drives four (a,b) vectors into a two-input gate, holds each HOLD_CYCLES
// cycles and compares the gate output against the selected function.
module gate_stim_checker #(
  parameter int HOLD_CYCLES = 4
) (
  input logic                clk,
  input logic                rst_n,
  gate_stim_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;

  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

  state_t     state_q;
  logic [7:0] holdCnt_q;
  logic [1:0] index_q;
  logic [1:0] opLatch_q;
  logic       a_q;
  logic       b_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic       mismatch_q;
  logic [2:0] errCount_q;
  logic [1:0] firstFail_q;

  logic       expected_d;
  logic       sampleNow_d;
  logic       fail_d;
  logic [2:0] errCount_d;

  // Vector order by index returns {a,b}: 00, 11, 01, 10.
  function automatic logic [1:0] vectorAB(input logic [1:0] idx);
    case (idx)
      2'd0:    vectorAB = 2'b00;
      2'd1:    vectorAB = 2'b11;
      2'd2:    vectorAB = 2'b01;
      default: vectorAB = 2'b10;
    endcase
  endfunction

  always_comb begin
    case (opLatch_q)
      2'b00:   expected_d = a_q & b_q;
      2'b01:   expected_d = a_q | b_q;
      2'b10:   expected_d = a_q ^ b_q;
      default: expected_d = ~(a_q & b_q);
    endcase
    sampleNow_d = (state_q == DRIVE) && (holdCnt_q == 8'd0);
    fail_d      = sampleNow_d && (bus.c != expected_d);
    errCount_d  = errCount_q;
    if (fail_d && (errCount_q != 3'd4))
      errCount_d = errCount_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      holdCnt_q   <= 8'd0;
      index_q     <= 2'd0;
      opLatch_q   <= 2'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      mismatch_q  <= 1'b0;
      errCount_q  <= 3'd0;
      firstFail_q <= 2'd0;
    end else begin
      mismatch_q <= fail_d;
      case (state_q)
        IDLE: begin
          a_q    <= 1'b0;
          b_q    <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            state_q      <= DRIVE;
            opLatch_q    <= bus.op;
            index_q      <= 2'd0;
            holdCnt_q    <= HOLD_RELOAD;
            errCount_q   <= 3'd0;
            firstFail_q  <= 2'd0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b1;
            {a_q, b_q}   <= vectorAB(2'd0);
          end
        end
        DRIVE: begin
          errCount_q <= errCount_d;
          if (fail_d && (errCount_q == 3'd0))
            firstFail_q <= index_q;
          if (holdCnt_q != 8'd0) begin
            holdCnt_q <= holdCnt_q - 8'd1;
          end else if (index_q != 2'd3) begin
            index_q    <= index_q + 2'd1;
            holdCnt_q  <= HOLD_RELOAD;
            {a_q, b_q} <= vectorAB(index_q + 2'd1);
          end else begin
            // Pass must include the verdict of the last vector sampled this cycle.
            state_q <= FINISH;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (errCount_d == 3'd0);
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.a          = a_q;
  assign bus.b          = b_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.mismatch   = mismatch_q;
  assign bus.err_count  = errCount_q;
  assign bus.first_fail = firstFail_q;

endmodule

// File: tb/tb_gate_stim_checker.sv
// Directed bench: a modelled gate (correct AND, tied 0, tied 1, XOR) sits
// behind the checker and each run is compared with hand-computed results.
module tb_gate_stim_checker;

  localparam int HOLD = 4;
  localparam logic [1:0] VEC [4] = '{2'b00, 2'b11, 2'b01, 2'b10};

  localparam logic [1:0] GATE_AND   = 2'd0;
  localparam logic [1:0] GATE_TIED0 = 2'd1;
  localparam logic [1:0] GATE_TIED1 = 2'd2;
  localparam logic [1:0] GATE_XOR   = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] gateMode;
  logic       gateC;
  int         checks = 0;
  int         failures = 0;

  gate_stim_checker_if bus ();

  gate_stim_checker #(.HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // The gate under test, selectable per run.
  always_comb begin
    case (gateMode)
      GATE_AND:   gateC = bus.a & bus.b;
      GATE_TIED0: gateC = 1'b0;
      GATE_TIED1: gateC = 1'b1;
      default:    gateC = bus.a ^ bus.b;
    endcase
  end
  assign bus.c = gateC;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " busy"}, int'(bus.busy), 0);
    checkOutput({tag, " done"}, int'(bus.done), 0);
    checkOutput({tag, " pass"}, int'(bus.pass), 0);
    checkOutput({tag, " mismatch"}, int'(bus.mismatch), 0);
    checkOutput({tag, " err_count"}, int'(bus.err_count), 0);
    checkOutput({tag, " first_fail"}, int'(bus.first_fail), 0);
    checkOutput({tag, " ab"}, int'({bus.a, bus.b}), 0);
  endtask

  // One full sequence; optionally re-pulses start and flips op mid-run.
  task automatic applyStimulus(input logic [1:0] opSel, input logic [1:0] mode,
                               input bit interfere, input int expErr, input int expFirst);
    int pulses = 0;
    gateMode = mode;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = opSel;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 4 * HOLD + 1; k++) begin
      if (k > 1) @(negedge clk);
      checkOutput("busy", int'(bus.busy), int'(k <= 4 * HOLD));
      checkOutput("done", int'(bus.done), int'(k > 4 * HOLD));
      if (k <= 4 * HOLD)
        checkOutput("ab", int'({bus.a, bus.b}), int'(VEC[(k - 1) / HOLD]));
      else
        checkOutput("ab finish", int'({bus.a, bus.b}), 0);
      if (bus.mismatch) pulses++;
      if (interfere && k == 5) begin
        bus.start = 1'b1;
        bus.op    = ~opSel;
      end else begin
        bus.start = 1'b0;
      end
    end
    checkOutput("pass", int'(bus.pass), int'(expErr == 0));
    checkOutput("err_count", int'(bus.err_count), expErr);
    checkOutput("first_fail", int'(bus.first_fail), expFirst);
    checkOutput("mismatch pulses", pulses, expErr);
    repeat (3) @(negedge clk);
    checkOutput("done held", int'(bus.done), 1);
    checkOutput("pass held", int'(bus.pass), int'(expErr == 0));
    checkOutput("err held", int'(bus.err_count), expErr);
    checkOutput("idle busy", int'(bus.busy), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    gateMode  = GATE_AND;
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;

    applyStimulus(2'b00, GATE_AND,   1'b0, 0, 0);
    applyStimulus(2'b00, GATE_TIED0, 1'b0, 1, 1);
    applyStimulus(2'b11, GATE_TIED1, 1'b0, 1, 1);
    applyStimulus(2'b11, GATE_TIED0, 1'b0, 3, 0);
    // XOR against AND expectation differs on (1,1), (0,1) and (1,0).
    applyStimulus(2'b00, GATE_XOR,   1'b0, 3, 1);
    applyStimulus(2'b00, GATE_AND,   1'b1, 0, 0);
    applyStimulus(2'b00, GATE_TIED0, 1'b1, 1, 1);

    // Abort during vector 2 after vector 1 already failed, with start held in reset.
    gateMode = GATE_TIED0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2 * HOLD + 1) @(negedge clk);
    checkOutput("pre-reset err_count", int'(bus.err_count), 1);
    rst_n     = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    checkResetValues("mid reset");
    @(negedge clk);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("post-reset busy", int'(bus.busy), 0);
    checkOutput("post-reset done", int'(bus.done), 0);
    applyStimulus(2'b00, GATE_AND, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
